// File: rtl/jtpopeye_dma.sv
// Vertical-blank DMA sequencer: copies the object table from main RAM into the object buffer.
// Optional grant watchdog in REQ is built only when JTPOPEYE_DMA_WATCHDOG_EN is defined.
module jtpopeye_dma #(
    parameter int unsigned DMA_LEN    = 768,
    parameter int unsigned GRANT_WAIT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       VB,
    output logic       busrq_n,
    input  logic       busak_n,
    output logic       dma_cs,
    output logic [9:0] AD_DMA,
    input  logic [7:0] DD_DMA,
    output logic [9:0] obj_addr,
    output logic [7:0] obj_dout,
    output logic       obj_we,
    output logic       busy,
    output logic       done,
    output logic       dma_err
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_XFER  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_REL   = 3'd4
    } state_t;

    localparam logic [9:0] LAST_ADDR = 10'(DMA_LEN - 1);

    state_t     state_q, state_d;
    logic       vbl_q, vbl_d;
    logic       busrq_n_q, busrq_n_d;
    logic       dma_cs_q, dma_cs_d;
    logic [9:0] ad_dma_q, ad_dma_d;
    logic [9:0] ad_prev_q, ad_prev_d;
    logic       fill_q, fill_d;
    logic [9:0] obj_addr_q, obj_addr_d;
    logic [7:0] obj_dout_q, obj_dout_d;
    logic       obj_we_q, obj_we_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       dma_err_q, dma_err_d;

`ifdef JTPOPEYE_DMA_WATCHDOG_EN
    localparam int WD_W = (GRANT_WAIT > 1) ? $clog2(GRANT_WAIT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(GRANT_WAIT - 1);
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
`else
    // Without the watchdog REQ waits indefinitely, so GRANT_WAIT has no effect.
    if (GRANT_WAIT == 0) begin : g_grant_wait_unused
    end
`endif

    // Next-state and registered-output computation for the DMA sequencer.
    always_comb begin
        state_d    = state_q;
        vbl_d      = VB;
        busrq_n_d  = busrq_n_q;
        dma_cs_d   = dma_cs_q;
        ad_dma_d   = ad_dma_q;
        ad_prev_d  = ad_dma_q;
        fill_d     = fill_q;
        obj_addr_d = obj_addr_q;
        obj_dout_d = obj_dout_q;
        obj_we_d   = 1'b0;
        done_d     = 1'b0;
        dma_err_d  = dma_err_q;
`ifdef JTPOPEYE_DMA_WATCHDOG_EN
        wd_cnt_d   = {WD_W{1'b0}};
`endif
        case (state_q)
            ST_IDLE: begin
                busrq_n_d = 1'b1;
                dma_cs_d  = 1'b0;
                if (VB && !vbl_q) begin
                    busrq_n_d = 1'b0;
                    dma_err_d = 1'b0;
                    state_d   = ST_REQ;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_REQ: begin
                busrq_n_d = 1'b0;
                if (!busak_n) begin
                    ad_dma_d = 10'd0;
                    dma_cs_d = 1'b1;
                    fill_d   = 1'b1;
                    state_d  = ST_XFER;
                end else begin
`ifdef JTPOPEYE_DMA_WATCHDOG_EN
                    if (wd_cnt_q == WD_LAST) begin
                        dma_err_d = 1'b1;
                        busrq_n_d = 1'b1;
                        state_d   = ST_REL;
                    end else begin
                        wd_cnt_d  = wd_cnt_q + {{(WD_W-1){1'b0}}, 1'b1};
                    end
`else
                    state_d = ST_REQ;
`endif
                end
            end
            ST_XFER: begin
                // A lost grant overrides everything, including the last-address exit.
                if (busak_n) begin
                    dma_err_d = 1'b1;
                    dma_cs_d  = 1'b0;
                    busrq_n_d = 1'b1;
                    state_d   = ST_REL;
                end else begin
                    fill_d = 1'b0;
                    if (!fill_q) begin
                        obj_we_d   = 1'b1;
                        obj_addr_d = ad_prev_q;
                        obj_dout_d = DD_DMA;
                    end else begin
                        obj_we_d   = 1'b0;
                    end
                    if (ad_dma_q == LAST_ADDR) begin
                        state_d  = ST_DRAIN;
                    end else begin
                        ad_dma_d = ad_dma_q + 10'd1;
                    end
                end
            end
            ST_DRAIN: begin
                obj_we_d   = 1'b1;
                obj_addr_d = LAST_ADDR;
                obj_dout_d = DD_DMA;
                dma_cs_d   = 1'b0;
                busrq_n_d  = 1'b1;
                done_d     = 1'b1;
                state_d    = ST_REL;
            end
            ST_REL: begin
                busrq_n_d = 1'b1;
                if (busak_n) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_REL;
                end
            end
            default: begin
                busrq_n_d = 1'b1;
                dma_cs_d  = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers, advancing only on cen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            vbl_q      <= 1'b0;
            busrq_n_q  <= 1'b1;
            dma_cs_q   <= 1'b0;
            ad_dma_q   <= 10'd0;
            ad_prev_q  <= 10'd0;
            fill_q     <= 1'b0;
            obj_addr_q <= 10'd0;
            obj_dout_q <= 8'd0;
            obj_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dma_err_q  <= 1'b0;
        end else if (cen) begin
            state_q    <= state_d;
            vbl_q      <= vbl_d;
            busrq_n_q  <= busrq_n_d;
            dma_cs_q   <= dma_cs_d;
            ad_dma_q   <= ad_dma_d;
            ad_prev_q  <= ad_prev_d;
            fill_q     <= fill_d;
            obj_addr_q <= obj_addr_d;
            obj_dout_q <= obj_dout_d;
            obj_we_q   <= obj_we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dma_err_q  <= dma_err_d;
        end
    end

`ifdef JTPOPEYE_DMA_WATCHDOG_EN
    // Grant watchdog counter, cleared whenever REQ is not waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q <= {WD_W{1'b0}};
        end else if (cen) begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`endif

    assign busrq_n  = busrq_n_q;
    assign dma_cs   = dma_cs_q;
    assign AD_DMA   = ad_dma_q;
    assign obj_addr = obj_addr_q;
    assign obj_dout = obj_dout_q;
    assign obj_we   = obj_we_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign dma_err  = dma_err_q;

endmodule
